// File: rtl/sub_pkg.sv
//------------------------------------------------------------------------------
// Module  : sub_pkg
// Brief   : Shared state encoding and default width for the serial subtractor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sub_pkg;

    localparam int SUB_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sub_state_t;

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
//------------------------------------------------------------------------------
// Module  : full_subtractor
// Brief   : One-bit full subtractor cell: diff = a - b - c with borrow out.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b ^ c;
    assign borrow = (~a & b) | (~a & c) | (b & c);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
//------------------------------------------------------------------------------
// Module  : serial_subtractor
// Brief   : Bit-serial unsigned subtractor, LSB first, one bit per clock,
//           with valid/ready handshakes on both sides.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bo_q, bo_d;

    logic             w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_full;

    full_subtractor u_fs (
        .a      (a_sr_q[0]),
        .b      (b_sr_q[0]),
        .c      (brw_q),
        .diff   (w_diff),
        .borrow (w_borrow)
    );

    // w_full is the complete result as it would look if this were the last
    // bit; only the upper WIDTH-1 bits ever need to be stored between cycles.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_full = w_diff;
        end else begin : g_wn
            logic [WIDTH-2:0] res_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_q <= '0;
                end else if (state_q == S_RUN) begin
                    res_q <= w_full[WIDTH-1:1];
                end
            end

            assign w_full = {w_diff, res_q};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bo_q    <= bo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bo_d    = bo_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                brw_d  = w_borrow;
                if (cnt_q == C_CNT_LAST) begin
                    // Publish into separate output registers so the result
                    // survives the next operation's RUN phase.
                    cnt_d   = '0;
                    diff_d  = w_full;
                    bo_d    = w_borrow;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign diff       = diff_q;
    assign borrow_out = bo_q;

endmodule

`default_nettype wire
